serial_pattern_detector: RTL and testbench

- Downstream stage of the team's gate-level master-slave D flip-flop chain. Consumes its serial Q stream as `sin` and shifts it into a WIDTH-bit window.
- Flags each occurrence of a fixed bit PATTERN and counts occurrences with saturation.
- Supports parallel preload of the window and selectable overlapping or non-overlapping detection.
- Synthesizable RTL; sits between the flop stages and the result/display logic.

---
 rtl/serial_pattern_detector.sv | 72 +++++++
 tb/tb_serial_pattern_detector.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_detector.sv
// Serial shift window that flags occurrences of PATTERN and keeps a saturating match count.
// The fill counter qualifies a match so that a partial window (or a consumed one when OVERLAP=0) never fires.
module serial_pattern_detector #(
  parameter int                 WIDTH   = 4,
  parameter logic [WIDTH-1:0]   PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 4
) (
  input  logic             clk,
  input  logic             R,
  input  logic             en,
  input  logic             sin,
  input  logic             load,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] q,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             overflow
);

  localparam int FILL_W = $clog2(WIDTH + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [WIDTH-1:0]  r_q;
  logic [FILL_W-1:0] r_fill;
  logic              r_match;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_ovf;

  logic [WIDTH-1:0]  w_q_shift;
  logic [FILL_W-1:0] w_fill_inc;
  logic              w_hit;

  // Window and fill as they will be after a shift edge; the match decision uses these.
  always_comb begin
    w_q_shift  = {r_q[WIDTH-2:0], sin};
    w_fill_inc = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 1'b1;
    w_hit      = (w_q_shift == PATTERN) && (w_fill_inc == FILL_FULL);
  end

  always_ff @(posedge clk) begin
    if (!R) begin
      r_q     <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else if (load) begin
      r_q     <= pin;
      r_fill  <= FILL_FULL;
      r_match <= 1'b0;
    end else if (en) begin
      r_q     <= w_q_shift;
      r_match <= w_hit;
      // Non-overlapping mode forces a complete refill before the next match.
      r_fill  <= (w_hit && !OVERLAP) ? '0 : w_fill_inc;
      if (w_hit) begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        else                  r_ovf <= 1'b1;
      end
    end else begin
      r_match <= 1'b0;
    end
  end

  assign q         = r_q;
  assign match     = r_match;
  assign match_cnt = r_cnt;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_pattern_detector.sv
// Directed bench for serial_pattern_detector: one instance per OVERLAP setting, shared stimulus,
// expected outputs queued on every driven edge and compared after that edge.
module tb_serial_pattern_detector;

  typedef struct packed {
    logic [3:0] q;
    logic       match;
    logic [3:0] cnt;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       R = 1'b0;
  logic       en = 1'b0;
  logic       sin = 1'b0;
  logic       load = 1'b0;
  logic [3:0] pin = 4'b0000;

  logic [3:0] q0, q1;
  logic       m0, m1;
  logic [3:0] c0, c1;
  logic       o0, o1;

  int n_eval = 0;
  int n_fail = 0;

  exp_t sb0[$];
  exp_t sb1[$];

  // Reference state, index = OVERLAP setting
  logic [3:0] mq[2];
  int         mf[2];
  logic       mm[2];
  logic [3:0] mc[2];
  logic       mo[2];

  always #5 clk = ~clk;

  serial_pattern_detector #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(4)) u_dut0 (
    .clk(clk), .R(R), .en(en), .sin(sin), .load(load), .pin(pin),
    .q(q0), .match(m0), .match_cnt(c0), .overflow(o0)
  );

  serial_pattern_detector #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(4)) u_dut1 (
    .clk(clk), .R(R), .en(en), .sin(sin), .load(load), .pin(pin),
    .q(q1), .match(m1), .match_cnt(c1), .overflow(o1)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_eval++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_edge(input logic r, input logic ld, input logic e, input logic s, input logic [3:0] p);
    exp_t x;
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        mq[k] = 4'b0000; mf[k] = 0; mm[k] = 1'b0; mc[k] = 4'd0; mo[k] = 1'b0;
      end else if (ld) begin
        mq[k] = p; mf[k] = 4; mm[k] = 1'b0;
      end else if (e) begin
        mq[k] = {mq[k][2:0], s};
        mf[k] = (mf[k] < 4) ? mf[k] + 1 : 4;
        mm[k] = (mq[k] == 4'b1011) && (mf[k] == 4);
        if (mm[k]) begin
          if (k == 0) mf[k] = 0;
          if (mc[k] == 4'd15) mo[k] = 1'b1;
          else mc[k] = mc[k] + 4'd1;
        end
      end else begin
        mm[k] = 1'b0;
      end
      x.q = mq[k]; x.match = mm[k]; x.cnt = mc[k]; x.ovf = mo[k];
      if (k == 0) sb0.push_back(x);
      else        sb1.push_back(x);
    end
  endtask

  // Drive one edge, predict it, then compare both instances against the popped expectations.
  task automatic step(input string tag, input logic r, input logic ld, input logic e,
                      input logic s, input logic [3:0] p);
    exp_t x0, x1;
    @(negedge clk);
    R = r; load = ld; en = e; sin = s; pin = p;
    model_edge(r, ld, e, s, p);
    @(posedge clk);
    #1;
    x0 = sb0.pop_front();
    x1 = sb1.pop_front();
    chk({tag, " ov0.q"},     {4'd0, q0}, {4'd0, x0.q});
    chk({tag, " ov0.match"}, {7'd0, m0}, {7'd0, x0.match});
    chk({tag, " ov0.cnt"},   {4'd0, c0}, {4'd0, x0.cnt});
    chk({tag, " ov0.ovf"},   {7'd0, o0}, {7'd0, x0.ovf});
    chk({tag, " ov1.q"},     {4'd0, q1}, {4'd0, x1.q});
    chk({tag, " ov1.match"}, {7'd0, m1}, {7'd0, x1.match});
    chk({tag, " ov1.cnt"},   {4'd0, c1}, {4'd0, x1.cnt});
    chk({tag, " ov1.ovf"},   {7'd0, o1}, {7'd0, x1.ovf});
    $display("step %-10s R=%b load=%b en=%b sin=%b pin=%b | ov0 q=%b m=%b c=%0d o=%b | ov1 q=%b m=%b c=%0d o=%b",
             tag, r, ld, e, s, p, q0, m0, c0, o0, q1, m1, c1, o1);
  endtask

  task automatic shift(input string tag, input logic s);
    step(tag, 1'b1, 1'b0, 1'b1, s, 4'b0000);
  endtask

  task automatic rst(input string tag);
    step(tag, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111);
  endtask

  logic [3:0] pat;

  initial begin
    for (int k = 0; k < 2; k++) begin
      mq[k] = 4'b0000; mf[k] = 0; mm[k] = 1'b0; mc[k] = 4'd0; mo[k] = 1'b0;
    end

    // Reset wins over load and en
    rst("rst1");
    rst("rst2");
    chk("rst q literal", {4'd0, q1}, 8'h00);

    // Basic and overlapping detection on stream 1,0,1,1,0,1,1
    shift("s1", 1'b1);
    shift("s2", 1'b0);
    shift("s3", 1'b1);
    shift("s4", 1'b1);
    chk("s4 match literal", {7'd0, m1}, 8'h01);
    shift("s5", 1'b0);
    shift("s6", 1'b1);
    shift("s7", 1'b1);
    chk("s7 ov1 cnt literal", {4'd0, c1}, 8'h02);
    chk("s7 ov0 cnt literal", {4'd0, c0}, 8'h01);

    // Load path
    rst("rst3");
    step("ld1011", 1'b1, 1'b1, 1'b0, 1'b0, 4'b1011);
    step("ld0101", 1'b1, 1'b1, 1'b0, 1'b0, 4'b0101);
    shift("ldsh1", 1'b1);
    step("ld_en", 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000);

    // Reach 1011 then hold three edges
    shift("h1", 1'b1);
    shift("h2", 1'b0);
    shift("h3", 1'b1);
    shift("h4", 1'b1);
    for (int i = 0; i < 3; i++) step($sformatf("hold%0d", i), 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);

    // Saturation: sixteen back-to-back 1011 groups
    rst("rst4");
    pat = 4'b1011;
    for (int n = 0; n < 16; n++)
      for (int b = 3; b >= 0; b--) shift($sformatf("sat%0d_%0d", n, b), pat[b]);
    chk("sat cnt literal", {4'd0, c1}, 8'h0F);
    chk("sat ovf literal", {7'd0, o1}, 8'h01);

    // Mid-pattern reset, then a fresh match counts from one
    shift("mid1", 1'b1);
    shift("mid2", 1'b0);
    step("midrst", 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
    for (int b = 3; b >= 0; b--) shift($sformatf("post%0d", b), pat[b]);
    chk("post cnt literal", {4'd0, c0}, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
    $finish;
  end

endmodule
